// File: rtl/score_text_ctrl.sv
// score_text_ctrl: "SCORE nnnn" label renderer with double-dabble BCD conversion and a 2-stage font pipeline.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits d3..d1.
module score_text_ctrl #(
    parameter int X0      = 480,
    parameter int Y0      = 64,
    parameter int SCORE_W = 14
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic [SCORE_W-1:0] SCORE,
    input  logic               SCORE_LD,
    output logic               BUSY,
    output logic [7:0]         FONT_ADDR,
    input  logic [7:0]         FONT_DATA,
    output logic               TEXT_ON
);
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t state;
    logic [SCORE_W-1:0] sh, pend_val;
    logic [15:0] bcd, adj, digits;
    logic [4:0] cnt;
    logic pend;
    logic [6:0] dx;
    logic [3:0] row, slot, code, d3, d2, d1;
    logic in_box, valid1;
    logic [2:0] col1;

    function automatic logic [SCORE_W-1:0] sat(input logic [SCORE_W-1:0] v);
        return (32'(v) > 32'd9999) ? SCORE_W'(32'd9999) : v;
    endfunction

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 4; i++)
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            sh       <= '0;
            pend_val <= '0;
            bcd      <= '0;
            digits   <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (SCORE_LD) begin
                    sh    <= sat(SCORE);
                    bcd   <= '0;
                    cnt   <= '0;
                    BUSY  <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: begin
                    bcd <= (adj << 1) | 16'(sh[SCORE_W-1]);
                    sh  <= sh << 1;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(SCORE_W - 1)) state <= COMMIT;
                    if (SCORE_LD) begin
                        pend     <= 1'b1;
                        pend_val <= SCORE;
                    end
                end
                COMMIT: begin
                    digits <= bcd;
                    // a strobe landing on this cycle beats any older pending value
                    if (pend || SCORE_LD) begin
                        sh    <= sat(SCORE_LD ? SCORE : pend_val);
                        bcd   <= '0;
                        cnt   <= '0;
                        pend  <= 1'b0;
                        state <= SHIFT;
                    end else begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dx     = 7'(DrawX - 10'(X0));
    assign row    = 4'(DrawY - 10'(Y0));
    assign slot   = dx[6:3];
    assign in_box = DrawX >= 10'(X0) && DrawX < 10'(X0 + 80) && DrawY >= 10'(Y0) && DrawY < 10'(Y0 + 16);

`ifdef LEADING_ZERO_BLANK_EN
    assign d3 = (digits[15:12] == 4'd0) ? 4'hF : digits[15:12];
    assign d2 = (digits[15:8] == 8'd0) ? 4'hF : digits[11:8];
    assign d1 = (digits[15:4] == 12'd0) ? 4'hF : digits[7:4];
`else
    assign d3 = digits[15:12];
    assign d2 = digits[11:8];
    assign d1 = digits[7:4];
`endif

    always_comb begin
        case (slot)
            4'd0:    code = 4'hE;
            4'd1:    code = 4'hA;
            4'd2:    code = 4'hC;
            4'd3:    code = 4'hD;
            4'd4:    code = 4'hB;
            4'd6:    code = d3;
            4'd7:    code = d2;
            4'd8:    code = d1;
            4'd9:    code = digits[3:0];
            default: code = 4'hF;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            FONT_ADDR <= 8'hF0;
            valid1    <= 1'b0;
            col1      <= 3'd0;
            TEXT_ON   <= 1'b0;
        end else begin
            FONT_ADDR <= {in_box ? code : 4'hF, row};
            valid1    <= in_box;
            col1      <= dx[2:0];
            TEXT_ON   <= valid1 & FONT_DATA[3'd7 - col1];
        end
    end
endmodule

// File: tb/tb_score_text_ctrl.sv
// tb_score_text_ctrl: vector table, corner sequences and random traffic against a decimal/timeline model.
module tb_score_text_ctrl;
    localparam int X0 = 480;
    localparam int Y0 = 64;
    localparam int SW = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [9:0] draw_x = '0;
    logic [9:0] draw_y = '0;
    logic [SW-1:0] score = '0;
    logic score_ld = 1'b0;
    logic busy, text_on;
    logic [7:0] font_addr, font_data;

    int checks = 0;
    int errors = 0;

    int m_left, m_cur, m_pv, m_shown;
    bit m_pend;
    logic [7:0] p_addr;
    bit p_in;
    int p_col;
    bit last_src_in;

    score_text_ctrl #(.X0(X0), .Y0(Y0), .SCORE_W(SW)) dut (
        .Clk(clk), .Reset_n(rst_n), .DrawX(draw_x), .DrawY(draw_y),
        .SCORE(score), .SCORE_LD(score_ld), .BUSY(busy),
        .FONT_ADDR(font_addr), .FONT_DATA(font_data), .TEXT_ON(text_on)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'hA5;
    endfunction

    assign font_data = rom(font_addr);

    function automatic int sat(input int v);
        return v > 9999 ? 9999 : v;
    endfunction

    function automatic bit in_box(input int x, input int y);
        return x >= X0 && x < X0 + 80 && y >= Y0 && y < Y0 + 16;
    endfunction

    function automatic logic [3:0] glyph(input byte ch);
        case (ch)
            "S": return 4'hE;
            "C": return 4'hA;
            "O": return 4'hC;
            "R": return 4'hD;
            "E": return 4'hB;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [7:0] exp_addr(input int x, input int y, input int v);
        string lab;
        int s, k, p;
        logic [3:0] code;
        lab = "SCORE ";
        s = (x - X0) / 8;
        if (!in_box(x, y)) code = 4'hF;
        else if (s < 6) code = glyph(lab[s]);
        else begin
            k = 9 - s;
            p = 1;
            repeat (k) p = p * 10;
            code = 4'((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
            if (k > 0 && v < p) code = 4'hF;
`endif
        end
        return {code, 4'(y % 16)};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_left = 0; m_cur = 0; m_pv = 0; m_shown = 0; m_pend = 0;
        p_addr = 8'hF0; p_in = 0; p_col = 0;
    endtask

    task automatic step(input int x, input int y, input bit ld, input int sc);
        logic [7:0] ea, d;
        bit et;
        draw_x = 10'(x); draw_y = 10'(y); score_ld = ld; score = SW'(sc);
        ea = exp_addr(x, y, m_shown);
        d = rom(p_addr);
        et = p_in && d[7 - p_col];
        last_src_in = p_in;
        if (m_left == 0) begin
            if (ld) begin m_cur = sat(sc); m_left = SW + 1; end
        end else begin
            if (ld) begin m_pend = 1; m_pv = sc; end
            m_left--;
            if (m_left == 0) begin
                m_shown = m_cur;
                if (m_pend) begin m_cur = sat(m_pv); m_pend = 0; m_left = SW + 1; end
            end
        end
        p_addr = ea; p_in = in_box(x, y); p_col = (x - X0) & 7;
        @(posedge clk);
        #1;
        chk("busy", busy, 32'(m_left != 0));
        chk("font_addr", font_addr, ea);
        chk("text_on", text_on, et);
        score_ld = 1'b0;
    endtask

    task automatic wait_idle(input int x, input int y);
        for (int i = 0; i < 40 && m_left != 0; i++) step(x, y, 0, 0);
    endtask

    typedef struct {
        int sc;
        int x;
        int y;
        logic [7:0] ea;
        string n;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int busy_cnt, seen7, viol, last_sc;
`ifdef LEADING_ZERO_BLANK_EN
        localparam bit BL = 1'b1;
`else
        localparam bit BL = 1'b0;
`endif
        tbl[0]  = '{1234,  X0+48, Y0+2,  8'h12, "d3_1234"};
        tbl[1]  = '{1234,  X0,    Y0+2,  8'hE2, "S_row2"};
        tbl[2]  = '{1234,  X0+79, Y0+15, 8'h4F, "d0_1234"};
        tbl[3]  = '{1234,  X0+16, Y0,    8'hC0, "O_row0"};
        tbl[4]  = '{1234,  X0+40, Y0+9,  8'hF9, "space"};
        tbl[5]  = '{1234,  X0-1,  Y0+2,  8'hF2, "left_out"};
        tbl[6]  = '{1234,  X0+80, Y0,    8'hF0, "right_out"};
        tbl[7]  = '{1234,  X0,    Y0+16, 8'hF0, "below_out"};
        tbl[8]  = '{16383, X0+48, Y0,    8'h90, "sat_d3"};
        tbl[9]  = '{16383, X0+79, Y0+5,  8'h95, "sat_d0"};
        tbl[10] = '{0,     X0+48, Y0+3,  BL ? 8'hF3 : 8'h03, "zero_d3"};
        tbl[11] = '{0,     X0+56, Y0+4,  BL ? 8'hF4 : 8'h04, "zero_d2"};
        tbl[12] = '{0,     X0+64, Y0+5,  BL ? 8'hF5 : 8'h05, "zero_d1"};
        tbl[13] = '{0,     X0+75, Y0+6,  8'h06, "zero_d0"};
        tbl[14] = '{42,    X0+56, Y0+1,  BL ? 8'hF1 : 8'h01, "d2_42"};
        tbl[15] = '{42,    X0+64, Y0+1,  8'h41, "d1_42"};

        reset_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_addr", font_addr, 8'hF0);
        chk("rst_text", text_on, 0);
        rst_n = 1'b1;

        // reset in the middle of a conversion
        step(X0, Y0, 1, 1234);
        wait_idle(X0, Y0);
        step(X0, Y0, 1, 5678);
        repeat (5) step(X0, Y0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", font_addr, 8'hF0);
        chk("midrst_text", text_on, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        reset_model();
        step(X0+72, Y0, 0, 0);
        chk("midrst_d0", font_addr, 8'h00);
        step(X0+48, Y0, 0, 0);
        chk("midrst_d3", font_addr, BL ? 8'hF0 : 8'h00);

        // loads while busy: latest pending wins, one extra conversion
        busy_cnt = 0; seen7 = 0;
        for (int i = 0; i < 40; i++) begin
            step(X0+72, Y0, i == 0 || i == 3 || i == 8, i == 0 ? 500 : (i == 3 ? 77 : 88));
            if (busy) busy_cnt++;
            if (font_addr == 8'h70) seen7++;
        end
        chk("pend_busy_len", busy_cnt, 30);
        chk("pend_no77", seen7, 0);
        chk("pend_d0", font_addr, 8'h80);
        step(X0+64, Y0, 0, 0);
        chk("pend_d1", font_addr, 8'h80);

        // strobe exactly on the commit cycle
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(X0+72, Y0+1, i == 0 || i == 15, i == 0 ? 321 : 654);
            if (busy) busy_cnt++;
        end
        chk("commit_ld_busy_len", busy_cnt, 30);
        chk("commit_ld_d0", font_addr, 8'h41);

        // table-driven pixel vectors
        last_sc = -1;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].sc != last_sc) begin
                step(X0, Y0, 1, tbl[i].sc);
                wait_idle(X0, Y0);
                last_sc = tbl[i].sc;
            end
            step(tbl[i].x, tbl[i].y, 0, 0);
            chk(tbl[i].n, font_addr, tbl[i].ea);
        end
        step(X0, Y0, 1, 1234);
        wait_idle(X0, Y0);
        step(X0+48, Y0+2, 0, 0);
        chk("addr_1234", font_addr, 8'h12);
        step(X0+48, Y0+2, 0, 0);
        chk("text_on_1234", text_on, 1);

        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(X0+95, X0-16), $urandom_range(Y0+19, Y0-4),
                 $urandom_range(19, 0) == 0, $urandom_range(16383, 0));
        wait_idle(X0, Y0);

        // raster sweep around the box
        viol = 0;
        for (int y = Y0 - 4; y < Y0 + 20; y++)
            for (int x = 0; x < 640; x++) begin
                step(x, y, 0, 0);
                if (text_on && !last_src_in) viol++;
            end
        chk("sweep_outside", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
